// File: rtl/framebuf_led_pkg.sv
// Shared widths, derived sizes and FSM encodings for the LED framebuffer scanner.
package framebuf_led_pkg;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 16;
    localparam int SLICE_W = 6;
    localparam int WORD_W  = 8;

    localparam int WORDS_PER_SLICE = 2 ** WORD_W;
    localparam int NUM_SLICES      = 2 ** SLICE_W;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_WAIT  = 3'd2;
    localparam state_t S_SHIFT = 3'd3;
    localparam state_t S_LATCH = 3'd4;
    localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/framebuf_led_shifter.sv
// Serializes one framebuffer word MSB-first with a divided shift clock.
module framebuf_led_shifter #(
    parameter int DATA_W   = 16,
    parameter int SCLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              start,
    output logic              sdi,
    output logic              sclk,
    output logic              word_done
);

    localparam int DW = $clog2(SCLK_DIV) + 1;
    localparam int BW = $clog2(DATA_W);

    logic [DATA_W-1:0] shreg;
    logic [DW-1:0]     div;
    logic [BW-1:0]     bit_cnt;
    logic              phase;
    logic              phase_end;

    assign phase_end = start && (div == DW'(SCLK_DIV - 1));

    // The register shifts as sclk falls, so sdi only moves while sclk is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            div     <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
        end else if (load) begin
            shreg   <= data;
            div     <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
        end else if (start) begin
            if (phase_end) begin
                div   <= '0;
                phase <= ~phase;
                if (phase) begin
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign sclk      = phase;
    assign sdi       = start & shreg[DATA_W-1];
    assign word_done = phase_end & phase & (bit_cnt == BW'(DATA_W - 1));

endmodule

// File: rtl/framebuf_led_scanner.sv
// Reads one 256-word slice from framebuffer port 2 per trigger and shifts it
// out to the LED driver chain, then latches the chain and reports completion.
module framebuf_led_scanner #(
    parameter int ADDR_W    = framebuf_led_pkg::ADDR_W,
    parameter int DATA_W    = framebuf_led_pkg::DATA_W,
    parameter int SLICE_W   = framebuf_led_pkg::SLICE_W,
    parameter int WORD_W    = framebuf_led_pkg::WORD_W,
    parameter int SCLK_DIV  = 2,
    parameter int LATCH_CYC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                slice_start,
    input  logic                frame_sync,
    output logic [ADDR_W-1:0]   address2,
    output logic                chipselect2,
    output logic                write2,
    output logic [DATA_W/8-1:0] byteenable2,
    output logic                clken2,
    input  logic [DATA_W-1:0]   readdata2,
    output logic                led_sdi,
    output logic                led_sclk,
    output logic                led_latch,
    output logic                led_blank,
    output logic                busy,
    output logic                slice_done,
    output logic [SLICE_W-1:0]  slice_idx,
    output logic                overrun
);

    import framebuf_led_pkg::*;

    localparam int LW = $clog2(LATCH_CYC) + 1;

    if (SLICE_W + WORD_W != ADDR_W) begin : g_width_check
        $error("SLICE_W + WORD_W must equal ADDR_W");
    end

    state_t             state;
    logic [WORD_W-1:0]  word_idx;
    logic [SLICE_W-1:0] slice_cnt;
    logic [LW-1:0]      lat_cnt;
    logic               blank_q;
    logic               sync_seen;
    logic               word_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            word_idx  <= '0;
            slice_idx <= '0;
            slice_cnt <= '0;
            lat_cnt   <= '0;
            blank_q   <= 1'b1;
            sync_seen <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (slice_start && busy) overrun <= 1'b1;
            if (frame_sync) begin
                slice_cnt <= '0;
                sync_seen <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (!enable) blank_q <= 1'b1;
                    if (slice_start && enable) begin
                        state     <= S_FETCH;
                        word_idx  <= '0;
                        sync_seen <= 1'b0;
                        slice_idx <= frame_sync ? '0 : slice_cnt;
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT:  state <= S_SHIFT;
                S_SHIFT: begin
                    if (word_done) begin
                        if (word_idx == '1) begin
                            state   <= S_LATCH;
                            lat_cnt <= '0;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_LATCH: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_cnt == LW'(LATCH_CYC - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    blank_q <= 1'b0;
                    state   <= S_IDLE;
                    // A frame_sync seen during the slice keeps the counter at 0.
                    if (sync_seen || frame_sync) slice_cnt <= '0;
                    else slice_cnt <= slice_idx + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    framebuf_led_shifter #(
        .DATA_W   (DATA_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (state == S_WAIT),
        .data      (readdata2),
        .start     (state == S_SHIFT),
        .sdi       (led_sdi),
        .sclk      (led_sclk),
        .word_done (word_done)
    );

    assign address2    = {slice_idx, word_idx};
    assign chipselect2 = (state == S_FETCH);
    assign write2      = 1'b0;
    assign byteenable2 = '1;
    assign clken2      = 1'b1;
    assign busy        = (state == S_FETCH) || (state == S_WAIT) ||
                         (state == S_SHIFT) || (state == S_LATCH);
    assign led_latch   = (state == S_LATCH);
    assign slice_done  = (state == S_DONE);
    assign led_blank   = (state == S_LATCH) || (blank_q && state != S_DONE);

endmodule

// File: tb/tb_framebuf_led_scanner.sv
// Directed bench: full-size scanner for stream/timing, small instance for slice sequencing.
module tb_framebuf_led_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Full-size instance
    logic        reset, enable, slice_start, frame_sync;
    logic [13:0] address2;
    logic        chipselect2, write2, clken2;
    logic [1:0]  byteenable2;
    logic [15:0] readdata2;
    logic        led_sdi, led_sclk, led_latch, led_blank;
    logic        busy, slice_done, overrun;
    logic [5:0]  slice_idx;

    framebuf_led_scanner dut (
        .clk(clk), .reset(reset), .enable(enable),
        .slice_start(slice_start), .frame_sync(frame_sync),
        .address2(address2), .chipselect2(chipselect2), .write2(write2),
        .byteenable2(byteenable2), .clken2(clken2), .readdata2(readdata2),
        .led_sdi(led_sdi), .led_sclk(led_sclk), .led_latch(led_latch),
        .led_blank(led_blank), .busy(busy), .slice_done(slice_done),
        .slice_idx(slice_idx), .overrun(overrun)
    );

    int          ram_mode = 0;
    logic [13:0] rd_addr = '0;
    always @(posedge clk) if (chipselect2) rd_addr <= address2;
    assign readdata2 = (ram_mode == 1) ? ((rd_addr == 14'd0) ? 16'h8001 : 16'h0000)
                                       : (16'hA5A5 ^ {2'b00, rd_addr});

    // Small instance: 4 slices of 4 words
    logic       s_reset, s_enable, s_start, s_sync;
    logic [3:0] s_addr;
    logic       s_cs, s_wr, s_clken;
    logic [1:0] s_be;
    logic [15:0] s_rdata;
    logic       s_sdi, s_sclk, s_latch, s_blank, s_busy, s_done, s_ovr;
    logic [1:0] s_idx;

    framebuf_led_scanner #(
        .ADDR_W(4), .DATA_W(16), .SLICE_W(2), .WORD_W(2),
        .SCLK_DIV(1), .LATCH_CYC(1)
    ) dut_s (
        .clk(clk), .reset(s_reset), .enable(s_enable),
        .slice_start(s_start), .frame_sync(s_sync),
        .address2(s_addr), .chipselect2(s_cs), .write2(s_wr),
        .byteenable2(s_be), .clken2(s_clken), .readdata2(s_rdata),
        .led_sdi(s_sdi), .led_sclk(s_sclk), .led_latch(s_latch),
        .led_blank(s_blank), .busy(s_busy), .slice_done(s_done),
        .slice_idx(s_idx), .overrun(s_ovr)
    );

    logic [3:0] s_rd = '0;
    always @(posedge clk) if (s_cs) s_rd <= s_addr;
    assign s_rdata = 16'h1234 ^ {12'h000, s_rd};

    // Monitors sample on the falling edge
    bit   bits_q[$];
    logic prev_sclk = 1'b0;
    int   lat_hi = 0, blank_bad = 0, done_cnt = 0, done_cyc = 0, bad_at_done = 0;
    always @(negedge clk) begin
        if (led_sclk && !prev_sclk) bits_q.push_back(led_sdi);
        prev_sclk = led_sclk;
        if (led_latch) begin
            lat_hi++;
            if (!led_blank) blank_bad++;
        end
        if (slice_done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy || led_blank) bad_at_done++;
        end
    end

    int s_first = 0, s_last = 0, s_reads = 0, s_done_cnt = 0, s_busy_cnt = 0;
    always @(negedge clk) begin
        if (s_cs) begin
            if (s_reads == 0) s_first = int'(s_addr);
            s_last = int'(s_addr);
            s_reads++;
        end
        if (s_done) s_done_cnt++;
        if (s_busy) s_busy_cnt++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        bits_q.delete();
        lat_hi = 0;
        blank_bad = 0;
        done_cnt = 0;
        bad_at_done = 0;
    endtask

    int t_start = 0;
    task automatic pulse_start(input logic sync);
        @(negedge clk);
        slice_start = 1'b1;
        frame_sync  = sync;
        t_start     = cyc;
        @(negedge clk);
        slice_start = 1'b0;
        frame_sync  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        bit en;
        bit sync_start;
        bit sync_mid;
        bit exp_ran;
        int exp_idx;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t tbl[10];
    logic [15:0] w;
    int errs, n;

    initial begin
        tbl[0] = '{1, 0, 0, 1, 0, 4'h0, 4'h3};
        tbl[1] = '{1, 0, 0, 1, 1, 4'h4, 4'h7};
        tbl[2] = '{1, 0, 0, 1, 2, 4'h8, 4'hB};
        tbl[3] = '{1, 0, 0, 1, 3, 4'hC, 4'hF};
        tbl[4] = '{1, 0, 0, 1, 0, 4'h0, 4'h3};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 0};
        tbl[6] = '{1, 0, 1, 1, 1, 4'h4, 4'h7};
        tbl[7] = '{1, 0, 0, 1, 0, 4'h0, 4'h3};
        tbl[8] = '{1, 1, 0, 1, 0, 4'h0, 4'h3};
        tbl[9] = '{1, 0, 0, 1, 1, 4'h4, 4'h7};

        reset = 1'b1; enable = 1'b1; slice_start = 1'b0; frame_sync = 1'b0;
        s_reset = 1'b1; s_enable = 1'b1; s_start = 1'b0; s_sync = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        s_reset = 1'b0;
        @(negedge clk);

        chk("rst_blank", led_blank, 1);
        chk("rst_busy", busy, 0);
        chk("rst_addr", address2, 0);
        chk("rst_cs", chipselect2, 0);
        chk("rst_sclk", led_sclk, 0);
        chk("rst_sdi", led_sdi, 0);
        chk("rst_latch", led_latch, 0);
        chk("rst_done", slice_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_idx", slice_idx, 0);
        chk("tie_write2", write2, 0);
        chk("tie_be", byteenable2, 2'b11);
        chk("tie_clken", clken2, 1);

        // Full slice 0 with the A5A5 pattern
        clear_mon();
        pulse_start(1'b0);
        wait_done(17100);
        chk("s0_done_seen", done_cnt, 1);
        chk("s0_latency", done_cyc - t_start, 16901);
        chk("s0_bits", bits_q.size(), 4096);
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            w = 16'hA5A5 ^ 16'(k);
            for (int b = 15; b >= 0; b--) begin
                if (k * 16 + 15 - b < bits_q.size())
                    if (bits_q[k * 16 + 15 - b] !== w[b]) errs++;
            end
        end
        chk("s0_stream_errs", errs, 0);
        chk("s0_latch_cycles", lat_hi, 4);
        chk("s0_blank_in_latch", blank_bad, 0);
        chk("s0_done_flags", bad_at_done, 0);
        @(negedge clk);
        chk("s0_idle_blank", led_blank, 0);
        chk("s0_idle_busy", busy, 0);
        chk("s0_idx", slice_idx, 0);

        // Slice 1 with a second trigger while busy
        clear_mon();
        pulse_start(1'b0);
        repeat (98) @(negedge clk);
        slice_start = 1'b1;
        @(negedge clk);
        slice_start = 1'b0;
        @(negedge clk);
        chk("ovr_set", overrun, 1);
        wait_done(17100);
        chk("ovr_latency", done_cyc - t_start, 16901);
        chk("ovr_idx", slice_idx, 1);
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("ovr_no_extra", n + done_cnt, 1);

        // Disabled trigger is ignored and forces blank
        enable = 1'b0;
        pulse_start(1'b0);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("dis_no_busy", n, 0);
        chk("dis_overrun_kept", overrun, 1);
        chk("dis_blank", led_blank, 1);
        enable = 1'b1;

        // 8001 at address 0 via frame_sync-with-start, then reset mid-shift
        ram_mode = 1;
        clear_mon();
        pulse_start(1'b1);
        n = 0;
        while (bits_q.size() < 16 && n < 300) begin
            @(negedge clk);
            n++;
        end
        w = '0;
        if (bits_q.size() >= 16)
            for (int i = 0; i < 16; i++) w[15 - i] = bits_q[i];
        chk("lat_word", w, 16'h8001);
        chk("lat_sync_idx", slice_idx, 0);
        repeat (30) @(negedge clk);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_blank", led_blank, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", address2, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_idx", slice_idx, 0);
        chk("mid_rst_sclk", led_sclk, 0);
        chk("mid_rst_cs", chipselect2, 0);
        reset = 1'b0;

        // Slice sequencing on the small instance
        for (int i = 0; i < 10; i++) begin
            s_first = 0; s_last = 0; s_reads = 0; s_done_cnt = 0; s_busy_cnt = 0;
            @(negedge clk);
            s_enable = tbl[i].en;
            s_start  = 1'b1;
            s_sync   = tbl[i].sync_start;
            @(negedge clk);
            s_start = 1'b0;
            s_sync  = 1'b0;
            if (tbl[i].sync_mid) begin
                repeat (10) @(negedge clk);
                s_sync = 1'b1;
                @(negedge clk);
                s_sync = 1'b0;
            end
            n = 0;
            while (s_done_cnt == 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("row%0d_ran", i), s_done_cnt, tbl[i].exp_ran);
            chk($sformatf("row%0d_idx", i), s_idx, tbl[i].exp_idx);
            chk($sformatf("row%0d_ovr", i), s_ovr, 0);
            if (tbl[i].exp_ran) begin
                chk($sformatf("row%0d_first", i), s_first, tbl[i].exp_first);
                chk($sformatf("row%0d_last", i), s_last, tbl[i].exp_last);
                chk($sformatf("row%0d_reads", i), s_reads, 4);
            end else begin
                chk($sformatf("row%0d_busy", i), s_busy_cnt, 0);
            end
            s_enable = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuf_led_scanner.md
Name: framebuf_led_scanner

Overview:
- Downstream consumer of port 2 of the dual-port LED framebuffer (16384 x 16-bit words, 2 bytelanes).
- Once per slice trigger, it reads one slice of 256 words from the framebuffer and serializes each word MSB-first onto the LED driver chain.
- It then latches the chain outputs and reports completion.
- It sits between the framebuffer and the LED driver pins, in the framebuffer's port-2 clock domain.

Parameters:
- ADDR_W, 14, framebuffer word-address width.
- DATA_W, 16, framebuffer word width = LEDs per word.
- SLICE_W, 6, slice index width; NUM_SLICES = 2**SLICE_W = 64.
- WORD_W, 8, word-in-slice index width; WORDS_PER_SLICE = 256. SLICE_W + WORD_W == ADDR_W; checked at elaboration.
- SCLK_DIV, 2, clk cycles per led_sclk phase (>=1).
- LATCH_CYC, 4, clk cycles led_latch is held high (>=1).

Ports:
- clk  in  1  single clock, same as framebuffer clk2.
- reset  in  1  synchronous, active-high.
- enable  in  1  when 0, slice_start is ignored.
- slice_start  in  1  one-cycle pulse requesting the next slice.
- frame_sync  in  1  one-cycle pulse that zeroes the slice counter.
- address2  out  14  framebuffer port-2 word address.
- chipselect2  out  1  framebuffer port-2 select.
- write2  out  1  tied 0.
- byteenable2  out  2  tied 2'b11.
- clken2  out  1  tied 1.
- readdata2  in  16  framebuffer port-2 read data.
- led_sdi  out  1  serial data to the driver chain.
- led_sclk  out  1  driver shift clock.
- led_latch  out  1  driver latch strobe.
- led_blank  out  1  driver output blank, active-high.
- busy  out  1  high while a slice is in progress.
- slice_done  out  1  one-cycle pulse at the end of each slice.
- slice_idx  out  6  index of the current or most recent slice.
- overrun  out  1  sticky; set when slice_start arrives while busy.

Behaviour:
- Reset values:
  - address2 = 0, chipselect2 = 0.
  - led_sdi = 0, led_sclk = 0, led_latch = 0, led_blank = 1.
  - busy = 0, slice_done = 0, overrun = 0.
  - slice_idx = 0, slice counter = 0, FSM = IDLE.
  - Reset mid-slice aborts immediately; all outputs return to reset values on the next edge.
- Read timing: the port-2 address is registered in RAM and output is unregistered, so read latency is 1 cycle. An address driven in cycle t yields readdata2 that is sampled at the end of cycle t+1.
- Address = {slice_idx, word_idx}, word_idx counting 0..255.
- FSM states: IDLE, FETCH, WAIT, SHIFT, LATCH, DONE.
  - IDLE -> FETCH on slice_start & enable. slice_idx is loaded from the slice counter (or 0 if frame_sync is also high that cycle), word_idx = 0, busy = 1.
  - FETCH: chipselect2 = 1, address2 = {slice_idx, word_idx}; next state WAIT.
  - WAIT: chipselect2 = 0; readdata2 is captured into the 16-bit shift register; bit_cnt = 0; next state SHIFT.
  - SHIFT: led_sdi = shreg[15], changed only while led_sclk = 0. led_sclk is low for SCLK_DIV cycles, then high for SCLK_DIV cycles, then the register shifts left. After 16 rising edges:
    - if word_idx != 255: word_idx++ and go to FETCH;
    - else go to LATCH.
  - LATCH: led_sdi = 0, led_sclk = 0; led_latch = 1 and led_blank = 1 for LATCH_CYC cycles; then DONE.
  - DONE: slice_done = 1 for one cycle; led_blank = 0; busy = 0; slice counter = slice_idx + 1 (wraps 63 -> 0); next state IDLE.
- Cycle counts:
  - Per word: 2 + 32*SCLK_DIV cycles.
  - Per slice (slice_start edge to slice_done): 256*(2 + 32*SCLK_DIV) + LATCH_CYC + 1 cycles; with defaults 16901.
- led_blank:
  - After the first DONE, stays 0 except during LATCH.
  - Forced to 1 from the next cycle whenever enable = 0 and the FSM is in IDLE.
- frame_sync: zeroes the slice counter on any cycle and does not abort a slice in progress; the following slice uses index 0.
- slice_start while busy: ignored; overrun is set, cleared only by reset.
- slice_start with enable = 0: ignored, no overrun.
- write2 is never asserted.

Decomposition:
- Package framebuf_led_pkg holds:
  - the default widths (ADDR_W, DATA_W, SLICE_W, WORD_W);
  - the FSM state enum;
  - the derived constants WORDS_PER_SLICE and NUM_SLICES.
- Sub-module framebuf_led_shifter contains the 16-bit shift register, the SCLK_DIV divider and bit_cnt.
  - Interface: load / data / start in; sdi / sclk / word_done out.
  - The top level keeps the FSM, the address counters and the latch/blank control.

Test Plan:
- Reset: hold reset 3 cycles mid-SHIFT -> next cycle led_blank = 1, busy = 0, address2 = 0, overrun = 0, slice_idx = 0.
- Single slice: RAM model word k = 16'hA5A5 ^ k; slice_start -> sdi stream on led_sclk rising edges equals words 0..255 MSB-first; slice_done exactly 16901 cycles after slice_start; led_latch high 4 cycles.
- Read latency: RAM model with exact 1-cycle latency returning 16'h8001 at address 0 -> first sdi bit 1, sixteenth bit 1, bits 2..15 all 0.
- Wrap: run 65 slices -> slice_idx sequence 0..63, 0; address2 of the 65th slice's first read = 14'h0000; last read of slice 63 = 14'h3FFF.
- Overrun and ignore: slice_start at cycle 100 of a busy slice -> overrun = 1, slice completes normally, no extra slice; slice_start with enable = 0 -> no activity, overrun unchanged.
- frame_sync: pulse during slice 5 -> slice 5 completes with slice_idx = 5; next slice_start gives slice_idx = 0; frame_sync coincident with slice_start -> slice_idx = 0.
